pipe_stage_reg: RTL and testbench

- Parametrised successor to the fixed-width inter-stage bus register (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds:
  - a per-stage valid bit with allow-in/over handshake on both sides;
  - flush and stall controls;
  - an optional skid buffer, so upstream allow-in is registered;
  - selectable bubble clearing;
  - a saturating back-pressure counter.
- Sits between two pipeline stages.
- Upstream drives data_i/up_valid_i; downstream consumes data_o/down_valid_o.

---
 rtl/pipe_stage_reg_if.sv | 29 ++
 rtl/pipe_stage_reg.sv | 101 ++++++++++
 tb/tb_pipe_stage_reg.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_reg_if.sv
// Stage-to-stage bus bundle for pipe_stage_reg: payload, valid/allow-in handshakes,
// pipeline controls and the back-pressure counter readout.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    // A beat moves across a side only on a rising edge where the producer's valid
    // and the consumer's allow-in are both high and stall_i is low. Valid must not
    // depend on allow-in; allow-in may depend on valid.
    logic              up_valid_i;
    logic              up_allow_in_o;
    logic [DATA_W-1:0] data_i;
    logic              down_allow_in_i;
    logic              down_valid_o;
    logic [DATA_W-1:0] data_o;
    logic              stall_i;
    logic              flush_i;
    logic [CNT_W-1:0]  bp_cnt_o;

    modport master (
        output up_valid_i, data_i, down_allow_in_i, stall_i, flush_i,
        input  up_allow_in_o, down_valid_o, data_o, bp_cnt_o
    );

    modport slave (
        input  up_valid_i, data_i, down_allow_in_i, stall_i, flush_i,
        output up_allow_in_o, down_valid_o, data_o, bp_cnt_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/allow-in handshake, flush, stall,
// optional skid entry, optional bubble clearing and a saturating back-pressure counter.
module pipe_stage_reg #(
    parameter int                 DATA_W          = 32,
    parameter logic [DATA_W-1:0]  RST_VAL         = '0,
    parameter int                 SKID            = 0,
    parameter int                 CLEAR_ON_BUBBLE = 0,
    parameter int                 CNT_W           = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    pipe_stage_reg_if.slave  bus
);
    logic              valid_q;
    logic              skid_valid_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] skid_q;
    logic [CNT_W-1:0]  bp_q;

    logic up_allow;
    logic in_fire;
    logic out_fire;
    logic bp_inc;

    // With a skid entry, allow-in depends only on registered state and stall, so
    // upstream never sees a combinational path from down_allow_in_i.
    always_comb begin
        up_allow = 1'b0;
        if (SKID != 0) begin
            up_allow = ~skid_valid_q & ~bus.stall_i;
        end else begin
            up_allow = ~bus.stall_i & (~valid_q | bus.down_allow_in_i);
        end
    end

    assign in_fire  = bus.up_valid_i & up_allow & ~bus.stall_i;
    assign out_fire = valid_q & bus.down_allow_in_i & ~bus.stall_i;
    assign bp_inc   = valid_q & ~bus.down_allow_in_i & ~bus.stall_i & ~bus.flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            data_q       <= RST_VAL;
            skid_q       <= RST_VAL;
            bp_q         <= '0;
        end else if (bus.flush_i) begin
            valid_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            data_q       <= RST_VAL;
            skid_q       <= RST_VAL;
        end else begin
            if (bp_inc && (bp_q != {CNT_W{1'b1}})) begin
                bp_q <= bp_q + 1'b1;
            end
            if (SKID == 0) begin
                if (in_fire) begin
                    data_q  <= bus.data_i;
                    valid_q <= 1'b1;
                end else if (out_fire) begin
                    valid_q <= 1'b0;
                    if (CLEAR_ON_BUBBLE != 0) begin
                        data_q <= RST_VAL;
                    end
                end
            end else begin
                if (out_fire) begin
                    if (skid_valid_q) begin
                        // Older skid beat advances; a same-cycle arrival refills the skid.
                        data_q <= skid_q;
                        if (in_fire) begin
                            skid_q <= bus.data_i;
                        end else begin
                            skid_valid_q <= 1'b0;
                        end
                    end else if (in_fire) begin
                        data_q <= bus.data_i;
                    end else begin
                        valid_q <= 1'b0;
                        if (CLEAR_ON_BUBBLE != 0) begin
                            data_q <= RST_VAL;
                        end
                    end
                end else if (in_fire) begin
                    if (valid_q) begin
                        skid_q       <= bus.data_i;
                        skid_valid_q <= 1'b1;
                    end else begin
                        data_q  <= bus.data_i;
                        valid_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.up_allow_in_o = up_allow;
    assign bus.down_valid_o  = valid_q;
    assign bus.data_o        = data_q;
    assign bus.bp_cnt_o      = bp_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: four configurations share one stimulus stream and are
// checked against a queue-based model of the beats each stage holds.
module tb_pipe_stage_reg;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uv = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dai = 1'b1;
  logic       stall = 1'b0;
  logic       flush = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // dut0: SKID=0; dut1: SKID=1; dut2: SKID=1, clear, CNT_W=2; dut3: SKID=0, clear, CNT_W=3
  function automatic int p_skid(int k);
    return (k == 1 || k == 2) ? 1 : 0;
  endfunction

  function automatic int p_clr(int k);
    return (k >= 2) ? 1 : 0;
  endfunction

  function automatic logic [7:0] p_rst(int k);
    case (k)
      2: return 8'h5A;
      3: return 8'hA5;
      default: return 8'h00;
    endcase
  endfunction

  function automatic int p_bpmax(int k);
    case (k)
      2: return 3;
      3: return 7;
      default: return 65535;
    endcase
  endfunction

  pipe_stage_reg_if #(.DATA_W(8), .CNT_W(16)) b0 ();
  pipe_stage_reg_if #(.DATA_W(8), .CNT_W(16)) b1 ();
  pipe_stage_reg_if #(.DATA_W(8), .CNT_W(2))  b2 ();
  pipe_stage_reg_if #(.DATA_W(8), .CNT_W(3))  b3 ();

  assign b0.up_valid_i = uv;  assign b0.data_i = din;  assign b0.down_allow_in_i = dai;
  assign b0.stall_i = stall;  assign b0.flush_i = flush;
  assign b1.up_valid_i = uv;  assign b1.data_i = din;  assign b1.down_allow_in_i = dai;
  assign b1.stall_i = stall;  assign b1.flush_i = flush;
  assign b2.up_valid_i = uv;  assign b2.data_i = din;  assign b2.down_allow_in_i = dai;
  assign b2.stall_i = stall;  assign b2.flush_i = flush;
  assign b3.up_valid_i = uv;  assign b3.data_i = din;  assign b3.down_allow_in_i = dai;
  assign b3.stall_i = stall;  assign b3.flush_i = flush;

  pipe_stage_reg #(.DATA_W(8), .RST_VAL(8'h00), .SKID(0), .CLEAR_ON_BUBBLE(0), .CNT_W(16))
    u0 (.clk_i(clk), .rst_i(rst), .bus(b0));
  pipe_stage_reg #(.DATA_W(8), .RST_VAL(8'h00), .SKID(1), .CLEAR_ON_BUBBLE(0), .CNT_W(16))
    u1 (.clk_i(clk), .rst_i(rst), .bus(b1));
  pipe_stage_reg #(.DATA_W(8), .RST_VAL(8'h5A), .SKID(1), .CLEAR_ON_BUBBLE(1), .CNT_W(2))
    u2 (.clk_i(clk), .rst_i(rst), .bus(b2));
  pipe_stage_reg #(.DATA_W(8), .RST_VAL(8'hA5), .SKID(0), .CLEAR_ON_BUBBLE(1), .CNT_W(3))
    u3 (.clk_i(clk), .rst_i(rst), .bus(b3));

  logic [3:0]  dv;
  logic [3:0]  ua;
  logic [7:0]  dq  [4];
  logic [31:0] bpv [4];

  assign dv = {b3.down_valid_o, b2.down_valid_o, b1.down_valid_o, b0.down_valid_o};
  assign ua = {b3.up_allow_in_o, b2.up_allow_in_o, b1.up_allow_in_o, b0.up_allow_in_o};
  assign dq[0] = b0.data_o;  assign dq[1] = b1.data_o;
  assign dq[2] = b2.data_o;  assign dq[3] = b3.data_o;
  assign bpv[0] = 32'(b0.bp_cnt_o);  assign bpv[1] = 32'(b1.bp_cnt_o);
  assign bpv[2] = 32'(b2.bp_cnt_o);  assign bpv[3] = 32'(b3.bp_cnt_o);

  // Reference model: each stage is a FIFO of at most 1 (no skid) or 2 beats.
  logic [7:0] exp_q [4][$];
  int         m_occ [4];
  int         m_bp [4];
  logic [7:0] m_idle [4];
  logic [7:0] last_issue [4];
  logic [3:0] m_allow;
  logic [3:0] m_in;
  logic [3:0] m_out;
  logic       seen_rst = 1'b0;

  always_comb begin
    m_allow = '0;
    m_in    = '0;
    m_out   = '0;
    for (int k = 0; k < 4; k++) begin
      if (p_skid(k) != 0) m_allow[k] = !stall && (m_occ[k] < 2);
      else                m_allow[k] = !stall && (m_occ[k] == 0 || dai);
      m_in[k]  = uv && m_allow[k];
      m_out[k] = (m_occ[k] > 0) && dai && !stall;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        exp_q[k].delete();
        m_occ[k]  <= 0;
        m_bp[k]   <= 0;
        m_idle[k] <= p_rst(k);
      end else if (flush) begin
        exp_q[k].delete();
        m_occ[k]  <= 0;
        m_idle[k] <= p_rst(k);
      end else begin
        if (m_occ[k] > 0 && !dai && !stall && m_bp[k] < p_bpmax(k)) m_bp[k] <= m_bp[k] + 1;
        if (m_in[k]) exp_q[k].push_back(din);
        m_occ[k] <= m_occ[k] + (m_in[k] ? 1 : 0) - (m_out[k] ? 1 : 0);
        if (m_out[k] && !m_in[k] && m_occ[k] == 1)
          m_idle[k] <= (p_clr(k) != 0) ? p_rst(k) : last_issue[k];
      end
    end
    if (rst) seen_rst <= 1'b1;
  end

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h expected=%0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Monitor: compares every stage output against the model; a beat leaving the
  // stage is popped from the expected queue.
  always @(negedge clk) begin
    if (seen_rst) begin
      for (int k = 0; k < 4; k++) begin
        check("down_valid", k, 32'(dv[k]), 32'(m_occ[k] > 0));
        check("up_allow", k, 32'(ua[k]), 32'(m_allow[k]));
        check("bp_cnt", k, bpv[k], 32'(m_bp[k]));
        if (m_occ[k] > 0) begin
          if (exp_q[k].size() == 0) begin
            check("queue_underrun", k, 32'(exp_q[k].size()), 32'(m_occ[k]));
          end else begin
            check("data_out", k, 32'(dq[k]), 32'(exp_q[k][0]));
            if (m_out[k] && !flush && !rst) last_issue[k] = exp_q[k].pop_front();
          end
        end else begin
          check("idle_data", k, 32'(dq[k]), 32'(m_idle[k]));
        end
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] d, input logic a, input logic s, input logic f);
    uv = v; din = d; dai = a; stall = s; flush = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    rst = 1'b0;
    step(0, 8'h00, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      check("rst_valid", k, 32'(dv[k]), 32'd0);
      check("rst_data", k, 32'(dq[k]), 32'(p_rst(k)));
      check("rst_bp", k, bpv[k], 32'd0);
      check("rst_allow", k, 32'(ua[k]), 32'd1);
    end

    // streaming
    step(1, 8'h10, 1, 0, 0);
    step(1, 8'h11, 1, 0, 0);
    step(1, 8'h12, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);

    // back-pressure into the skid entry
    step(1, 8'hA1, 1, 0, 0);
    step(1, 8'hA2, 0, 0, 0);
    check("skid_full_allow", 1, 32'(ua[1]), 32'd0);
    step(1, 8'hA3, 0, 0, 0);
    step(1, 8'hA3, 0, 0, 0);
    step(1, 8'hA3, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0);

    // flush with both entries full
    step(1, 8'hB1, 0, 0, 0);
    step(1, 8'hB2, 0, 0, 0);
    step(1, 8'hB3, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      check("flush_valid", k, 32'(dv[k]), 32'd0);
      check("flush_data", k, 32'(dq[k]), 32'(p_rst(k)));
    end
    step(0, 8'h00, 1, 0, 0);

    // stall holds a valid beat
    step(1, 8'hC5, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 1, 0);
    check("stall_hold", 0, 32'(dq[0]), 32'hC5);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, 0);

    // bubble clearing
    step(1, 8'hD7, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    check("bubble_clear", 2, 32'(dq[2]), 32'h5A);
    check("bubble_clear", 3, 32'(dq[3]), 32'hA5);
    check("bubble_hold", 0, 32'(dq[0]), 32'hD7);

    // saturation of the narrow counter
    step(1, 8'hE1, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 0, 0);
    check("bp_saturate", 2, bpv[2], 32'd3);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);

    // randomized traffic, including occasional flush, stall and reset
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      step(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 255)),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 39) == 0));
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
